fwd_hazard_unit: RTL and testbench

//   Forwarding and load-use hazard controller for the 16-bit MIPS pipeline.

---
 rtl/fwd_hazard_if.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 148 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_if.sv
// Bus between the ID stage and the forwarding/hazard unit.
// It carries the ID instruction fields in, and the operand selects, stall and statistics out.
interface fwd_hazard_if #(
    parameter int REG_AW = 3,
    parameter int STAT_W = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic              bubble;
    logic [STAT_W-1:0] stat_stalls;
    logic [STAT_W-1:0] stat_fwds;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread,
        input  fwd_a, fwd_b, stall, bubble, stat_stalls, stat_fwds
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread,
        output fwd_a, fwd_b, stall, bubble, stat_stalls, stat_fwds
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller for the 16-bit MIPS pipeline.
// Optional saturating stall/forward counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_AW = 3,
    parameter int STAT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    fwd_hazard_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              hazard;
    logic              stall;
    logic              load_ex;
    logic [1:0]        fwd_a_nxt;
    logic [1:0]        fwd_b_nxt;

    logic [REG_AW-1:0] ex_dest_p1;
    logic              ex_regwrite_p1;
    logic              ex_memread_p1;
    logic [1:0]        fwd_a_p1;
    logic [1:0]        fwd_b_p1;
    logic [REG_AW-1:0] mem_dest_p2;
    logic              mem_regwrite_p2;

    // EX is the newer producer, so it takes priority over MEM; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] ex_d,
        input logic              ex_w,
        input logic [REG_AW-1:0] mem_d,
        input logic              mem_w
    );
        if (src == '0)
            return 2'b00;
        else if (ex_w && (ex_d == src))
            return 2'b10;
        else if (mem_w && (mem_d == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hazard = bus.id_valid && ex_memread_p1 && (ex_dest_p1 != '0) &&
                 ((ex_dest_p1 == bus.id_rs) || (ex_dest_p1 == bus.id_rt));
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            RUN: begin
                stall = hazard;
                if (hazard)
                    state_nxt = STALL;
            end
            STALL: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        load_ex   = bus.id_valid && !stall;
        fwd_a_nxt = fwd_sel(bus.id_rs, ex_dest_p1, ex_regwrite_p1, mem_dest_p2, mem_regwrite_p2);
        fwd_b_nxt = fwd_sel(bus.id_rt, ex_dest_p1, ex_regwrite_p1, mem_dest_p2, mem_regwrite_p2);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // ID -> EX (p1) and EX -> MEM (p2) control; a bubble clears regwrite/memread and the selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_regwrite_p1  <= 1'b0;
            ex_memread_p1   <= 1'b0;
            fwd_a_p1        <= 2'b00;
            fwd_b_p1        <= 2'b00;
            mem_regwrite_p2 <= 1'b0;
        end else begin
            mem_regwrite_p2 <= ex_regwrite_p1;
            if (load_ex) begin
                ex_regwrite_p1 <= bus.id_regwrite;
                ex_memread_p1  <= bus.id_memread;
                fwd_a_p1       <= fwd_a_nxt;
                fwd_b_p1       <= fwd_b_nxt;
            end else begin
                ex_regwrite_p1 <= 1'b0;
                ex_memread_p1  <= 1'b0;
                fwd_a_p1       <= 2'b00;
                fwd_b_p1       <= 2'b00;
            end
        end
    end

    // Destination indices are only meaningful alongside regwrite, so they carry no reset.
    always_ff @(posedge clk) begin
        mem_dest_p2 <= ex_dest_p1;
        if (load_ex)
            ex_dest_p1 <= bus.id_dest;
    end

    assign bus.fwd_a  = fwd_a_p1;
    assign bus.fwd_b  = fwd_b_p1;
    assign bus.stall  = stall;
    assign bus.bubble = stall;

`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] stalls_cnt;
    logic [STAT_W-1:0] fwds_cnt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == '1)
            return v;
        else
            return v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stalls_cnt <= '0;
            fwds_cnt   <= '0;
        end else begin
            if (stall)
                stalls_cnt <= sat_inc(stalls_cnt);
            if (load_ex && ((fwd_a_nxt != 2'b00) || (fwd_b_nxt != 2'b00)))
                fwds_cnt <= sat_inc(fwds_cnt);
        end
    end

    assign bus.stat_stalls = stalls_cnt;
    assign bus.stat_fwds   = fwds_cnt;
`else
    assign bus.stat_stalls = '0;
    assign bus.stat_fwds   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: each ID issue pushes its expected stall/bubble/select
// word, and the observed word is popped and compared by the scenario task that issued it.
module tb_fwd_hazard_unit;
    localparam int REG_AW = 3;
    localparam int STAT_W = 6;
`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        string      nm;
        logic [5:0] v;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    ent_t exp_q[$];
    ent_t obs_q[$];

    fwd_hazard_if #(.REG_AW(REG_AW), .STAT_W(STAT_W)) bus ();

    fwd_hazard_unit #(.REG_AW(REG_AW), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    function automatic logic [5:0] ew(input logic s, input logic [1:0] a, input logic [1:0] b);
        return {s, s, a, b};
    endfunction

    // Called at posedge+1; drives ID, samples stall before the edge and selects after it.
    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] dest, input logic rw, input logic mr,
                         input logic [5:0] expw, input string nm);
        ent_t e;
        ent_t o;
        logic s_obs;
        logic b_obs;
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_dest     = dest;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        e.nm = nm;
        e.v  = expw;
        exp_q.push_back(e);
        #2;
        s_obs = bus.stall;
        b_obs = bus.bubble;
        @(posedge clk);
        #1;
        o.nm = nm;
        o.v  = {s_obs, b_obs, bus.fwd_a, bus.fwd_b};
        obs_q.push_back(o);
    endtask

    task automatic flush();
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "flush_nop1");
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "flush_nop2");
    endtask

    task automatic test_reset();
        ent_t e;
        ent_t o;
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_dest = '0;
        bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got stall/bub/a/b=%b required %b",
                     {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b}, 6'b0);
        end
        checks++;
        if (bus.stat_stalls !== '0 || bus.stat_fwds !== '0) begin
            errors++;
            $display("FAIL reset_stats: got stalls=%0d fwds=%0d required 0 0",
                     bus.stat_stalls, bus.stat_fwds);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "reset_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
    endtask

    task automatic test_ex_forward();
        ent_t e;
        ent_t o;
        flush();
        drive(1'b1, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "exfwd_add_r1");
        drive(1'b1, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0, ew(1'b0, 2'b10, 2'b00), "exfwd_add_r4_r1");
        drive(1'b1, 3'd6, 3'd4, 3'd2, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b10), "exfwd_b_r4");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
    endtask

    task automatic test_mem_forward();
        ent_t e;
        ent_t o;
        flush();
        drive(1'b1, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "memfwd_add_r1");
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "memfwd_nop");
        drive(1'b1, 3'd7, 3'd1, 3'd6, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b01), "memfwd_sub_r1");
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "memfwd_nop2");
        drive(1'b1, 3'd6, 3'd6, 3'd2, 1'b0, 1'b0, ew(1'b0, 2'b01, 2'b01), "memfwd_both_r6");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        ent_t e;
        ent_t o;
        logic [STAT_W-1:0] exp_st;
        flush();
        drive(1'b1, 3'd2, 3'd0, 3'd4, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "lu_lw_r4");
        drive(1'b1, 3'd4, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b1, 2'b00, 2'b00), "lu_stall");
        drive(1'b1, 3'd4, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b0, 2'b01, 2'b01), "lu_add_after");
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "lu_nop");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
        exp_st = STATS ? STAT_W'(1) : '0;
        checks++;
        if (bus.stat_stalls !== exp_st) begin
            errors++;
            $display("FAIL lu_stat_stalls: got %0d required %0d", bus.stat_stalls, exp_st);
        end
    endtask

    task automatic test_r0_and_priority();
        ent_t e;
        ent_t o;
        flush();
        drive(1'b1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "r0_add_r0");
        drive(1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "r0_lw_r0");
        drive(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "r0_use_nostall");
        flush();
        drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "prio_mem_r3");
        drive(1'b1, 3'd4, 3'd5, 3'd3, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "prio_ex_r3");
        drive(1'b1, 3'd3, 3'd3, 3'd6, 1'b1, 1'b0, ew(1'b0, 2'b10, 2'b10), "prio_use_r3");
        flush();
        drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, ew(1'b0, 2'b00, 2'b00), "nowrite_r3");
        drive(1'b1, 3'd3, 3'd2, 3'd6, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "nowrite_use");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        ent_t e;
        ent_t o;
        flush();
        drive(1'b1, 3'd2, 3'd0, 3'd4, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "rms_lw_r4");
        bus.id_valid = 1'b1; bus.id_rs = 3'd4; bus.id_rt = 3'd1; bus.id_dest = 3'd5;
        bus.id_regwrite = 1'b1; bus.id_memread = 1'b0;
        #2;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL rms_stall_before_reset: got %b required 1", bus.stall);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b} !== 6'b0) begin
            errors++;
            $display("FAIL rms_after_reset: got stall/bub/a/b=%b required %b",
                     {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b}, 6'b0);
        end
        checks++;
        if (bus.stat_stalls !== '0) begin
            errors++;
            $display("FAIL rms_stat_cleared: got %0d required 0", bus.stat_stalls);
        end
        @(posedge clk);
        #1;
        drive(1'b1, 3'd4, 3'd1, 3'd5, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b00), "rms_add_noslot");
        drive(1'b1, 3'd2, 3'd0, 3'd4, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "rms_lw_again");
        drive(1'b1, 3'd1, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b1, 2'b00, 2'b00), "rms_stall_again");
        drive(1'b1, 3'd1, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b0, 2'b00, 2'b01), "rms_add_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        ent_t o;
        logic [STAT_W-1:0] exp_sat;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Each lw r4 then add r5,r4,r4 pair costs exactly one stall and one forwarding issue.
        for (int i = 0; i < (1 << STAT_W) + 5; i++) begin
            drive(1'b1, 3'd2, 3'd0, 3'd4, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00), "b2b_lw");
            drive(1'b1, 3'd4, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b1, 2'b00, 2'b00), "b2b_stall");
            drive(1'b1, 3'd4, 3'd4, 3'd5, 1'b1, 1'b0, ew(1'b0, 2'b01, 2'b01), "b2b_add");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.v !== e.v) begin
                errors++;
                $display("FAIL %s: got stall/bub/a/b=%b required %b", e.nm, o.v, e.v);
            end
        end
        exp_sat = STATS ? '1 : '0;
        checks++;
        if (bus.stat_stalls !== exp_sat) begin
            errors++;
            $display("FAIL b2b_stat_stalls_sat: got %0d required %0d", bus.stat_stalls, exp_sat);
        end
        checks++;
        if (bus.stat_fwds !== exp_sat) begin
            errors++;
            $display("FAIL b2b_stat_fwds_sat: got %0d required %0d", bus.stat_fwds, exp_sat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_r0_and_priority();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
